// File: rtl/sbus_pkg.sv
// Shared SBUS types: word/address typedefs, responder state encoding and the
// quad-word request-mask helper used to step through requested words.
package sbus_pkg;

  localparam int SBUS_QUAD_WORDS = 4;
  localparam int CNT_W           = 8;

  typedef logic [0:35]  tWord;
  typedef logic [14:35] tPMA;
  typedef logic [0:SBUS_QUAD_WORDS-1] tReqMask;

  typedef enum logic [2:0] {
    IDLE,
    ACK_WAIT,
    ACK,
    ACCESS,
    XFER,
    NXM_DROP
  } tSBUSstate;

  // First word at or after 'from' (wrapping inside the quad) whose mask bit is set.
  function automatic logic [1:0] next_req_word(input tReqMask mask, input logic [1:0] from);
    logic [1:0] k;
    next_req_word = from;
    for (int i = SBUS_QUAD_WORDS - 1; i >= 0; i--) begin
      k = from + 2'(i);
      if (mask[k]) next_req_word = k;
    end
  endfunction

endpackage

// File: rtl/sbus_mem_array.sv
// Main memory array: one write port and one synchronous read port, 37-bit words
// ({parity, data}); contents survive reset.
module sbus_mem_array #(
  parameter int WORDS = 65536,
  parameter int AW    = $clog2(WORDS),
  parameter int DW    = 37
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sbus_mem_responder.sv
// Memory-side SBUS responder: acknowledges MBOX quad requests and streams the
// requested words to or from the memory array; nonexistent addresses are never acked.
//
// state    | meaning
// IDLE     | waiting for a fresh START edge
// ACK_WAIT | acknowledge delay countdown
// ACK      | ACKN pulse
// ACCESS   | read access countdown while the first word is prefetched
// XFER     | one requested word per cycle, DATA_VALID high
// NXM_DROP | nonexistent address, hold BUSY until START drops
module sbus_mem_responder
  import sbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 65536,
  parameter int unsigned ACK_DELAY    = 2,
  parameter int unsigned ACCESS_DELAY = 3
) (
  input  logic         clk,
  input  logic         CROBAR,
  input  logic         START,
  input  logic         RD_RQ,
  input  logic [0:3]   RQ,
  input  logic [14:35] ADR,
  input  logic [0:35]  DATA_IN,
  input  logic         DATA_IN_PAR,
  output logic         ACKN,
  output logic         DATA_VALID,
  output logic [0:35]  DATA_OUT,
  output logic         DATA_OUT_PAR,
  output logic [34:35] WORD_NUM,
  output logic         BUSY
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = AW - 2;
  localparam logic [CNT_W-1:0] ACK_CNT_INIT =
    CNT_W'(ACK_DELAY > 1 ? ACK_DELAY - 2 : 0);
  localparam logic [CNT_W-1:0] ACC_CNT_INIT =
    CNT_W'(ACCESS_DELAY > 1 ? ACCESS_DELAY - 2 : 0);

  tSBUSstate         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [1:0]        ptr, ptr_nxt;
  tReqMask           mask, mask_nxt, mask_left;
  logic              rd_q;
  logic [BW-1:0]     base_q;
  logic              start_d;
  logic              accept;
  logic              adr_nxm;
  logic              mem_we;
  logic [36:0]       rd_data;

  assign accept  = (state == IDLE) && START && !start_d;
  assign adr_nxm = (32'(ADR) >= MEM_WORDS);

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      mask    <= '0;
      rd_q    <= 1'b0;
      base_q  <= '0;
      start_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ptr     <= ptr_nxt;
      mask    <= mask_nxt;
      start_d <= START;
      if (accept) begin
        rd_q   <= RD_RQ;
        base_q <= ADR[36-AW:33];
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    ptr_nxt         = ptr;
    mask_nxt        = mask;
    mask_left       = mask;
    mask_left[ptr]  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (adr_nxm) begin
            state_nxt = NXM_DROP;
          end else begin
            state_nxt = (ACK_DELAY > 1) ? ACK_WAIT : ACK;
            cnt_nxt   = ACK_CNT_INIT;
            mask_nxt  = RQ;
            ptr_nxt   = next_req_word(RQ, ADR[34:35]);
          end
        end
      end
      ACK_WAIT: begin
        if (cnt == '0) state_nxt = ACK;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      ACK: begin
        if (mask == '0) begin
          state_nxt = IDLE;
        end else if (rd_q && (ACCESS_DELAY > 1)) begin
          state_nxt = ACCESS;
          cnt_nxt   = ACC_CNT_INIT;
        end else begin
          state_nxt = XFER;
        end
      end
      ACCESS: begin
        if (cnt == '0) state_nxt = XFER;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      XFER: begin
        mask_nxt = mask_left;
        if (mask_left == '0) state_nxt = IDLE;
        else                 ptr_nxt   = next_req_word(mask_left, ptr + 2'd1);
      end
      NXM_DROP: begin
        if (!START) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read address follows ptr_nxt so the word shown next cycle is already fetched.
  assign mem_we = (state == XFER) && !rd_q;

  sbus_mem_array #(
    .WORDS (int'(MEM_WORDS)),
    .AW    (AW),
    .DW    (37)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr ({base_q, ptr}),
    .wdata ({DATA_IN_PAR, DATA_IN}),
    .raddr ({base_q, ptr_nxt}),
    .rdata (rd_data)
  );

  always_comb begin
    ACKN         = 1'b0;
    DATA_VALID   = 1'b0;
    DATA_OUT     = '0;
    DATA_OUT_PAR = 1'b0;
    WORD_NUM     = '0;
    BUSY         = (state != IDLE);
    case (state)
      ACK: ACKN = 1'b1;
      XFER: begin
        DATA_VALID = 1'b1;
        WORD_NUM   = ptr;
        if (rd_q) begin
          DATA_OUT     = rd_data[35:0];
          DATA_OUT_PAR = rd_data[36];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sbus_mem_responder.sv
// Directed bench for sbus_mem_responder: scoreboard of expected words per
// request, latency checks against the default delays, NXM, abort and parity cases.
module tb_sbus_mem_responder;
  import sbus_pkg::*;

  localparam int unsigned MEM_WORDS = 65536;

  logic         clk = 1'b0;
  logic         CROBAR;
  logic         START;
  logic         RD_RQ;
  logic [0:3]   RQ;
  logic [14:35] ADR;
  logic [0:35]  DATA_IN;
  logic         DATA_IN_PAR;
  logic         ACKN;
  logic         DATA_VALID;
  logic [0:35]  DATA_OUT;
  logic         DATA_OUT_PAR;
  logic [34:35] WORD_NUM;
  logic         BUSY;

  typedef struct packed {
    logic [1:0]  wn;
    logic [35:0] data;
    logic        par;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb [$];
  logic [36:0] model [int];
  logic [35:0] wdat [4];
  logic        wpar [4];
  int          nxm_ack;
  int          nxm_dv;

  always #5 clk = ~clk;

  sbus_mem_responder #(
    .MEM_WORDS    (MEM_WORDS),
    .ACK_DELAY    (2),
    .ACCESS_DELAY (3)
  ) dut (
    .clk          (clk),
    .CROBAR       (CROBAR),
    .START        (START),
    .RD_RQ        (RD_RQ),
    .RQ           (RQ),
    .ADR          (ADR),
    .DATA_IN      (DATA_IN),
    .DATA_IN_PAR  (DATA_IN_PAR),
    .ACKN         (ACKN),
    .DATA_VALID   (DATA_VALID),
    .DATA_OUT     (DATA_OUT),
    .DATA_OUT_PAR (DATA_OUT_PAR),
    .WORD_NUM     (WORD_NUM),
    .BUSY         (BUSY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ackn"},  ACKN, 0);
    check({tag, "_dv"},    DATA_VALID, 0);
    check({tag, "_data"},  DATA_OUT, 0);
    check({tag, "_par"},   DATA_OUT_PAR, 0);
    check({tag, "_wnum"},  WORD_NUM, 0);
    check({tag, "_busy"},  BUSY, 0);
  endtask

  function automatic logic odd_par(input logic [35:0] d);
    return ~^d;
  endfunction

  // One SBUS request. Cycle t=0 is the cycle START is presented; with default delays
  // ACKN is expected at t=2, read data from t=5, write data from t=3.
  task automatic sbus_req(input logic rd, input logic [0:3] rq, input logic [21:0] adr,
                          input int extra_start, input int abort_after);
    int          vis [$];
    int          k;
    int          t;
    int          ack_cnt;
    int          dv_cnt;
    int          first_dv;
    int          exp_idle;
    int          wi;
    bit          done;
    logic [21:0] a;
    exp_t        e;

    for (int i = 0; i < 4; i++) begin
      k = (int'(adr[1:0]) + i) % 4;
      if (rq[k]) vis.push_back(k);
    end
    foreach (vis[j]) begin
      a = {adr[21:2], 2'(vis[j])};
      if (rd) begin
        if (model.exists(int'(a)))
          sb.push_back({2'(vis[j]), model[int'(a)][35:0], model[int'(a)][36]});
        else
          sb.push_back({2'(vis[j]), 36'd0, 1'b0});
      end else begin
        model[int'(a)] = {wpar[vis[j]], wdat[vis[j]]};
        sb.push_back({2'(vis[j]), 36'd0, 1'b0});
      end
    end

    @(negedge clk);
    START = 1'b1;
    RD_RQ = rd;
    RQ    = rq;
    ADR   = adr;
    if (!rd && vis.size() > 0) begin
      DATA_IN     = wdat[vis[0]];
      DATA_IN_PAR = wpar[vis[0]];
    end
    wi       = 1;
    ack_cnt  = 0;
    dv_cnt   = 0;
    first_dv = -1;
    done     = 1'b0;
    exp_idle = (vis.size() == 0) ? 3 : ((rd ? 5 : 3) + vis.size());

    for (t = 1; t <= 40 && !done; t++) begin
      @(negedge clk);
      if (t == 1) START = 1'b0;
      if (extra_start > 0 && t == extra_start) begin
        START = 1'b1;
        ADR   = '1;
        RQ    = ~rq;
        RD_RQ = ~rd;
      end
      if (extra_start > 0 && t == extra_start + 1) START = 1'b0;

      if (ACKN) begin
        ack_cnt++;
        check("ackn_cycle", t, 2);
      end
      if (DATA_VALID) begin
        dv_cnt++;
        if (first_dv < 0) begin
          first_dv = t;
          check("first_dv_cycle", t, rd ? 5 : 3);
        end
        if (sb.size() == 0) begin
          check("dv_count_live", dv_cnt, vis.size());
        end else begin
          e = sb.pop_front();
          check("word_num", WORD_NUM, e.wn);
          check("data_out", DATA_OUT, e.data);
          check("data_par", DATA_OUT_PAR, e.par);
        end
        if (abort_after > 0 && dv_cnt == abort_after) begin
          @(posedge clk);
          #1;
          CROBAR = 1'b1;
          #1;
          check_outputs_zero("abort");
          @(negedge clk);
          CROBAR = 1'b0;
          sb.delete();
          return;
        end
        if (!rd && wi < vis.size()) begin
          @(posedge clk);
          #1;
          DATA_IN     = wdat[vis[wi]];
          DATA_IN_PAR = wpar[vis[wi]];
          wi++;
        end
      end
      if (!BUSY) begin
        done = 1'b1;
        check("idle_cycle", t, exp_idle);
      end
    end
    check("busy_done", done, 1);
    check("ack_count", ack_cnt, 1);
    check("dv_count", dv_cnt, vis.size());
    check("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    CROBAR      = 1'b1;
    START       = 1'b0;
    RD_RQ       = 1'b0;
    RQ          = 4'b0000;
    ADR         = '0;
    DATA_IN     = '0;
    DATA_IN_PAR = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    CROBAR = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Read quad with wrap from word 2.
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 36'o111 * (i + 1);
      wpar[i] = odd_par(wdat[i]);
    end
    sbus_req(1'b0, 4'b1111, 22'o1000, 0, 0);
    sbus_req(1'b1, 4'b1111, 22'o1002, 0, 0);

    // Sparse write over a preloaded quad, then read the whole quad back.
    for (int i = 0; i < 4; i++) begin
      wdat[i] = 36'o6000 + 36'(i);
      wpar[i] = odd_par(wdat[i]);
    end
    sbus_req(1'b0, 4'b1111, 22'o2000, 0, 0);
    wdat[0] = 36'o7;
    wdat[1] = 36'o777777;
    wdat[2] = 36'o5;
    wdat[3] = 36'o666666;
    for (int i = 0; i < 4; i++) wpar[i] = odd_par(wdat[i]);
    sbus_req(1'b0, 4'b1010, 22'o2000, 0, 0);
    sbus_req(1'b1, 4'b1111, 22'o2000, 0, 0);

    // Bad parity is stored and returned untouched.
    wdat[0] = 36'o0;
    wpar[0] = 1'b0;
    sbus_req(1'b0, 4'b1000, 22'o0, 0, 0);
    sbus_req(1'b1, 4'b1000, 22'o0, 0, 0);

    // Nonexistent address: no ACKN or data, BUSY held until START drops.
    @(negedge clk);
    START   = 1'b1;
    RD_RQ   = 1'b1;
    RQ      = 4'b1111;
    ADR     = tPMA'(MEM_WORDS + 4);
    nxm_ack = 0;
    nxm_dv  = 0;
    repeat (20) begin
      @(negedge clk);
      if (ACKN) nxm_ack++;
      if (DATA_VALID) nxm_dv++;
      check("nxm_busy", BUSY, 1);
    end
    check("nxm_ackn", nxm_ack, 0);
    check("nxm_dv", nxm_dv, 0);
    START = 1'b0;
    @(negedge clk);
    check("nxm_busy_drop", BUSY, 0);
    sbus_req(1'b1, 4'b1111, 22'o2000, 0, 0);

    // Reset after the second data word, then a clean read of the same quad.
    sbus_req(1'b1, 4'b1111, 22'o1000, 0, 2);
    sbus_req(1'b1, 4'b1111, 22'o1000, 0, 0);

    // Extra START while busy is ignored; masked words are skipped.
    sbus_req(1'b1, 4'b0110, 22'o1003, 4, 0);
    // Empty request mask: ACKN only.
    sbus_req(1'b1, 4'b0000, 22'o1000, 2, 0);
    sbus_req(1'b1, 4'b1111, 22'o1001, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
